// File: rtl/mul_32u_if.sv
// mul_32u_if: operand/result handshake shared with the divider.
interface mul_32u_if #(parameter int N = 32);
    logic [N-1:0]   X;
    logic [N-1:0]   Y;
    logic           in_valid;
    logic [2*N-1:0] P;
    logic           ovf;
    logic           out_valid;
    logic           busy;
    modport master(output X, Y, in_valid, input P, ovf, out_valid, busy);
    modport slave(input X, Y, in_valid, output P, ovf, out_valid, busy);
endinterface

// File: rtl/mul_32u.sv
// mul_32u: sequential radix-2 shift-add unsigned multiplier, one product in flight.
module mul_32u #(parameter int N = 32) (
    input logic     clk,
    input logic     rst,
    mul_32u_if.slave bus
);
    localparam int CW = $clog2(N) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;
    state_t         state, state_nx;
    logic [2*N-1:0] mcand, acc, p;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           ovf, accept, last;
    assign accept = (state == IDLE || state == DONE) && bus.in_valid;
    // FIN is the extra edge that registers the result after the final step
    assign last = cnt == CW'(N - 1) || mplier[N-1:1] == '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (accept) state_nx = (bus.X == '0 || bus.Y == '0) ? FIN : CALC;
        else if (state == CALC) state_nx = last ? FIN : CALC;
        else if (state == FIN) state_nx = DONE;
    end
    always_comb begin
        bus.busy      = state == CALC || state == FIN;
        bus.out_valid = state == DONE;
        bus.P         = p;
        bus.ovf       = ovf;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            mcand  <= {{N{1'b0}}, bus.X};
            mplier <= bus.Y;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end else if (state == FIN) begin
            p   <= acc;
            ovf <= |acc[2*N-1:N];
        end
endmodule

// File: doc/mul_32u.md
Name: mul_32u

Overview:
- Sequential unsigned N-bit multiplier using radix-2 shift-add; performs the inverse operation of the div_32u divider.
- Uses the same operand/valid handshake as div_32u: X, Y and in_valid in; result plus out_valid out.
- Sits beside div_32u in the arithmetic unit. Divider results can be fed back through it for self-checking: Q*Y+R == X.
- One product in flight at a time; no pipelining.

Parameters:
- N, 32, operand width in bits; product width is 2N.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset; the same port name as elsewhere in the codebase, with polarity fixed low-active for this block.
- X  input  N  multiplicand, unsigned.
- Y  input  N  multiplier, unsigned.
- in_valid  input  1  operands valid; sampled only when the block is not busy.
- P  output  2N  product X*Y, unsigned.
- ovf  output  1  high when P[2N-1:N] != 0, i.e. the product does not fit in N bits.
- out_valid  output  1  P and ovf hold a valid result.
- busy  output  1  a calculation is in progress; in_valid is ignored while high.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, P=0, ovf=0, out_valid=0, busy=0, internal counter and accumulator cleared.
- States:
  - IDLE: waiting for operands.
  - CALC: iterating.
  - DONE: result held.
- Accept: on a rising edge in IDLE or DONE with in_valid=1, latch X into mcand (zero-extended to 2N) and Y into mplier, clear acc, set cnt=0, out_valid=0, busy=1.
- Zero fast path: if X==0 or Y==0 at accept, skip CALC. The next edge loads P=0, ovf=0, out_valid=1, busy=0 and moves to DONE (latency 1).
- CALC, one step per edge:
  - if mplier[0], acc += mcand (2N-bit add, cannot overflow);
  - mcand <<= 1; mplier >>= 1; cnt++.
- Leaving CALC: after the step with cnt==N-1, or with mplier==0 after the shift (early exit), go to DONE. This consumes no extra step. The edge after that last step registers P=acc, ovf=|acc[2N-1:N], out_valid=1, busy=0.
- Latency, with the accept edge counted as edge 0:
  - worst case (Y has bit N-1 set): out_valid rises at edge N+1;
  - with early exit: out_valid rises at edge (index of highest set bit of Y)+2.
- DONE: P, ovf and out_valid hold indefinitely until the next accept or reset. A new accept drops out_valid on that same edge.
- in_valid is level-sampled. If it is still high when the block reaches DONE, the same operands are re-accepted, so sources must drop in_valid after 1-2 cycles. in_valid while busy=1 has no effect.
- X and Y may change freely after the accept edge; the block uses only the latched copies.
- Reset mid-CALC aborts the operation immediately: out_valid=0, and the partial product is discarded.
- Width rules: cnt is ceil(log2 N)+1 bits. All arithmetic is unsigned. Max product (2^N-1)^2 must be exact in 2N bits.
- Size target: about 150-250 lines; an FSM plus datapath in a single module.

Test Plan:
- Reset, then X=7, Y=6, in_valid for 1 cycle -> out_valid at edge 4 (Y MSB is bit 2), P=42, ovf=0, busy low at the same edge.
- X=32'hFFFFFFFF, Y=32'hFFFFFFFF -> out_valid at edge 33, P=64'hFFFFFFFE00000001, ovf=1; P holds for 50+ cycles while in_valid=0.
- X=0, Y=32'h12345678 and X=5, Y=0 -> out_valid at edge 1, P=0, ovf=0; then X=32'h10000, Y=32'h10000 -> P=64'h100000000, ovf=1.
- Start X=3, Y=32'h80000000; at edge 5 pulse in_valid with X=9, Y=9 -> ignored; result is P=64'h180000000. Then assert rst=0 mid-CALC of a second op -> out_valid=0, busy=0 asynchronously; a subsequent X=2, Y=3 gives P=6.
- Random regression, 10000 pairs (seed 1): one accept per op; wait for out_valid; P must equal X*Y in 64 bits and ovf must equal (P>>32)!=0. Also cross-check against div_32u: the product of Q*Y plus R must equal X, with zero mismatches.
